// File: rtl/ctrl_pkg.sv
// Shared definitions for the KGP-RISC multicycle control unit.
// Holds the sequencer state encoding, opcode/func numbering, ALU select
// codes, datapath mux encodings and the registered control bundle layout.
package ctrl_pkg;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4,
      ST_TRAP   = 3'd5
   } state_t;

   // Opcodes
   localparam int unsigned OP_ALU   = 0;
   localparam int unsigned OP_LOGIC = 1;
   localparam int unsigned OP_SHIFT = 2;
   localparam int unsigned OP_DIFF  = 3;
   localparam int unsigned OP_ADDI  = 4;
   localparam int unsigned OP_COMPI = 5;
   localparam int unsigned OP_LW    = 6;
   localparam int unsigned OP_SW    = 7;
   localparam int unsigned OP_BLTZ  = 8;
   localparam int unsigned OP_BZ    = 9;
   localparam int unsigned OP_BNZ   = 10;
   localparam int unsigned OP_BR    = 11;
   localparam int unsigned OP_B     = 12;
   localparam int unsigned OP_BL    = 13;
   localparam int unsigned OP_BCY   = 14;
   localparam int unsigned OP_BNCY  = 15;

   // Function codes, per opcode
   localparam int unsigned FN_ADD   = 0;   // OP_ALU
   localparam int unsigned FN_COMP  = 1;
   localparam int unsigned FN_AND   = 0;   // OP_LOGIC
   localparam int unsigned FN_XOR   = 1;
   localparam int unsigned FN_SHLL  = 0;   // OP_SHIFT
   localparam int unsigned FN_SHRL  = 1;
   localparam int unsigned FN_SHLLV = 2;
   localparam int unsigned FN_SHRLV = 3;
   localparam int unsigned FN_SHRA  = 4;
   localparam int unsigned FN_SHRAV = 5;

   // ALU operation select codes
   localparam int unsigned ALU_CODE_W = 5;
   localparam logic [ALU_CODE_W-1:0] ALU_ADD  = 5'b00001;
   localparam logic [ALU_CODE_W-1:0] ALU_COMP = 5'b00010;
   localparam logic [ALU_CODE_W-1:0] ALU_AND  = 5'b00011;
   localparam logic [ALU_CODE_W-1:0] ALU_XOR  = 5'b00100;
   localparam logic [ALU_CODE_W-1:0] ALU_DIFF = 5'b00101;
   localparam logic [ALU_CODE_W-1:0] ALU_ADDR = 5'b00110;
   localparam logic [ALU_CODE_W-1:0] ALU_SRL  = 5'b01000;
   localparam logic [ALU_CODE_W-1:0] ALU_SRA  = 5'b01001;
   localparam logic [ALU_CODE_W-1:0] ALU_SLL  = 5'b01010;

   // Datapath mux encodings
   localparam logic [1:0] PCS_PC4   = 2'b00;
   localparam logic [1:0] PCS_LABEL = 2'b01;
   localparam logic [1:0] PCS_REG   = 2'b10;

   localparam logic [1:0] RD_RD     = 2'b00;
   localparam logic [1:0] RD_RT     = 2'b01;
   localparam logic [1:0] RD_LINK   = 2'b10;

   localparam logic [1:0] M2R_PC    = 2'b00;
   localparam logic [1:0] M2R_MEM   = 2'b01;
   localparam logic [1:0] M2R_ALU   = 2'b10;

   typedef enum logic [2:0] {
      CL_ALU   = 3'd0,
      CL_LOAD  = 3'd1,
      CL_STORE = 3'd2,
      CL_BCOND = 3'd3,
      CL_JREG  = 3'd4,
      CL_JUMP  = 3'd5,
      CL_LINK  = 3'd6
   } instr_class_t;

   typedef struct packed {
      instr_class_t          cls;
      logic [ALU_CODE_W-1:0] alu_code;
      logic                  alu_src;
      logic                  alu_ipsel;
   } ctrl_bundle_t;

endpackage

// File: rtl/instr_decoder.sv
// Combinational instruction decoder.
// Ports:
//   opcode  - opcode field of the instruction register
//   func    - function field of the instruction register
//   bundle  - decoded control bundle (class + ALU controls)
//   invalid - opcode or opcode/func combination is undefined
module instr_decoder
   import ctrl_pkg::*;
#(
   parameter int unsigned OPCODE_W = 6,
   parameter int unsigned FUNC_W   = 5
) (
   input  logic [OPCODE_W-1:0] opcode,
   input  logic [FUNC_W-1:0]   func,
   output ctrl_bundle_t        bundle,
   output logic                invalid
);

   logic [31:0] op_x;
   logic [31:0] fn_x;

   always_comb begin
      op_x    = 32'(opcode);
      fn_x    = 32'(func);
      bundle  = '0;
      invalid = 1'b0;
      case (op_x)
         OP_ALU: begin
            case (fn_x)
               FN_ADD:  bundle.alu_code = ALU_ADD;
               FN_COMP: begin
                  bundle.alu_code  = ALU_COMP;
                  bundle.alu_ipsel = 1'b1;
               end
               default: invalid = 1'b1;
            endcase
         end
         OP_LOGIC: begin
            case (fn_x)
               FN_AND:  bundle.alu_code = ALU_AND;
               FN_XOR:  bundle.alu_code = ALU_XOR;
               default: invalid = 1'b1;
            endcase
         end
         OP_SHIFT: begin
            case (fn_x)
               FN_SHLL: begin
                  bundle.alu_code = ALU_SLL;
                  bundle.alu_src  = 1'b1;
               end
               FN_SHRL: begin
                  bundle.alu_code = ALU_SRL;
                  bundle.alu_src  = 1'b1;
               end
               FN_SHLLV: bundle.alu_code = ALU_SLL;
               FN_SHRLV: bundle.alu_code = ALU_SRL;
               FN_SHRA: begin
                  bundle.alu_code = ALU_SRA;
                  bundle.alu_src  = 1'b1;
               end
               FN_SHRAV: bundle.alu_code = ALU_SRA;
               default:  invalid = 1'b1;
            endcase
         end
         OP_DIFF: bundle.alu_code = ALU_DIFF;
         OP_ADDI: begin
            bundle.alu_code = ALU_ADD;
            bundle.alu_src  = 1'b1;
         end
         OP_COMPI: begin
            bundle.alu_code  = ALU_COMP;
            bundle.alu_src   = 1'b1;
            bundle.alu_ipsel = 1'b1;
         end
         OP_LW: begin
            bundle.cls      = CL_LOAD;
            bundle.alu_code = ALU_ADDR;
            bundle.alu_src  = 1'b1;
         end
         OP_SW: begin
            bundle.cls      = CL_STORE;
            bundle.alu_code = ALU_ADDR;
            bundle.alu_src  = 1'b1;
         end
         OP_BLTZ, OP_BZ, OP_BNZ, OP_BCY, OP_BNCY: bundle.cls = CL_BCOND;
         OP_BR:   bundle.cls = CL_JREG;
         OP_B:    bundle.cls = CL_JUMP;
         OP_BL:   bundle.cls = CL_LINK;
         default: invalid = 1'b1;
      endcase
   end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle sequencing control unit for the KGP-RISC datapath.
// Steps each instruction through FETCH/DECODE/EXEC/MEM/WB, handshaking with
// a variable-latency shared memory; undefined instructions lock into TRAP
// until reset.
// Ports:
//   clk, rst_n           - clock, synchronous active-low reset
//   opcode, func         - instruction register fields
//   mem_ready            - memory completes the current request
//   branch_taken         - branch condition result
//   hold                 - freeze sequencing and suppress writes
//   mem_req/mem_we/iord  - memory request, write, data-address select
//   ir_write/pc_write    - IR and PC load enables, pc_src PC source select
//   reg_write/reg_dest/mem_to_reg - register-file write controls
//   alu_src/alu_ipsel/alu_opsel   - ALU operand and operation selects
//   illegal              - sticky trap flag
//   state_o              - current state for debug
module multicycle_control_unit
   import ctrl_pkg::*;
#(
   parameter int unsigned OPCODE_W = 6,
   parameter int unsigned FUNC_W   = 5,
   parameter int unsigned ALUSEL_W = 5
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic [FUNC_W-1:0]   func,
   input  logic                mem_ready,
   input  logic                branch_taken,
   input  logic                hold,
   output logic                mem_req,
   output logic                mem_we,
   output logic                iord,
   output logic                ir_write,
   output logic                pc_write,
   output logic [1:0]          pc_src,
   output logic                reg_write,
   output logic [1:0]          reg_dest,
   output logic [1:0]          mem_to_reg,
   output logic                alu_src,
   output logic                alu_ipsel,
   output logic [ALUSEL_W-1:0] alu_opsel,
   output logic                illegal,
   output logic [2:0]          state_o
);

   state_t       state;
   ctrl_bundle_t bundle_q;
   ctrl_bundle_t dec_bundle;
   logic         dec_invalid;
   logic         illegal_q;

   instr_decoder #(
      .OPCODE_W (OPCODE_W),
      .FUNC_W   (FUNC_W)
   ) u_instr_decoder (
      .opcode  (opcode),
      .func    (func),
      .bundle  (dec_bundle),
      .invalid (dec_invalid)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= ST_FETCH;
         bundle_q  <= '0;
         illegal_q <= 1'b0;
      end else if (!hold) begin
         case (state)
            ST_FETCH: if (mem_ready) state <= ST_DECODE;
            ST_DECODE: begin
               if (dec_invalid) begin
                  state     <= ST_TRAP;
                  illegal_q <= 1'b1;
               end else begin
                  bundle_q <= dec_bundle;
                  state    <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               case (bundle_q.cls)
                  CL_ALU:            state <= ST_WB;
                  CL_LOAD, CL_STORE: state <= ST_MEM;
                  default:           state <= ST_FETCH;
               endcase
            end
            ST_MEM: begin
               if (mem_ready) state <= (bundle_q.cls == CL_LOAD) ? ST_WB : ST_FETCH;
            end
            ST_WB:   state <= ST_FETCH;
            ST_TRAP: state <= ST_TRAP;
            default: state <= ST_FETCH;
         endcase
      end
   end

   // Outputs decode from state + registered bundle; reset low forces every
   // output (including mem_req and state_o) to zero, and hold masks only
   // the write enables so a pending request stays visible.
   always_comb begin
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      iord       = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_src     = PCS_PC4;
      reg_write  = 1'b0;
      reg_dest   = RD_RD;
      mem_to_reg = M2R_PC;
      alu_src    = 1'b0;
      alu_ipsel  = 1'b0;
      alu_opsel  = '0;
      illegal    = 1'b0;
      state_o    = '0;
      if (rst_n) begin
         state_o = state;
         illegal = illegal_q;
         if (state == ST_EXEC || state == ST_MEM || state == ST_WB) begin
            alu_src   = bundle_q.alu_src;
            alu_ipsel = bundle_q.alu_ipsel;
            alu_opsel = ALUSEL_W'(bundle_q.alu_code);
         end
         case (state)
            ST_FETCH: begin
               mem_req = 1'b1;
               if (mem_ready) begin
                  ir_write = 1'b1;
                  pc_write = 1'b1;
                  pc_src   = PCS_PC4;
               end
            end
            ST_EXEC: begin
               case (bundle_q.cls)
                  CL_BCOND: begin
                     pc_write = branch_taken;
                     pc_src   = PCS_LABEL;
                  end
                  CL_JREG: begin
                     pc_write = 1'b1;
                     pc_src   = PCS_REG;
                  end
                  CL_JUMP: begin
                     pc_write = 1'b1;
                     pc_src   = PCS_LABEL;
                  end
                  CL_LINK: begin
                     pc_write   = 1'b1;
                     pc_src     = PCS_LABEL;
                     reg_write  = 1'b1;
                     reg_dest   = RD_LINK;
                     mem_to_reg = M2R_PC;
                  end
                  default: ;
               endcase
            end
            ST_MEM: begin
               mem_req = 1'b1;
               iord    = 1'b1;
               mem_we  = (bundle_q.cls == CL_STORE);
            end
            ST_WB: begin
               reg_write = 1'b1;
               if (bundle_q.cls == CL_LOAD) begin
                  reg_dest   = RD_RT;
                  mem_to_reg = M2R_MEM;
               end else begin
                  reg_dest   = RD_RD;
                  mem_to_reg = M2R_ALU;
               end
            end
            default: ;
         endcase
         if (hold) begin
            pc_write  = 1'b0;
            ir_write  = 1'b0;
            reg_write = 1'b0;
            mem_we    = 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench for multicycle_control_unit: each stimulus cycle pushes
// its hand-computed expected output vector; a negedge monitor pops and
// compares against the DUT outputs.
module tb_multicycle_control_unit;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [5:0] opcode;
   logic [4:0] func;
   logic       mem_ready;
   logic       branch_taken;
   logic       hold;
   logic       mem_req, mem_we, iord, ir_write, pc_write;
   logic [1:0] pc_src;
   logic       reg_write;
   logic [1:0] reg_dest, mem_to_reg;
   logic       alu_src, alu_ipsel;
   logic [4:0] alu_opsel;
   logic       illegal;
   logic [2:0] state_o;

   always #5 clk = ~clk;

   multicycle_control_unit #(
      .OPCODE_W (6),
      .FUNC_W   (5),
      .ALUSEL_W (5)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .opcode       (opcode),
      .func         (func),
      .mem_ready    (mem_ready),
      .branch_taken (branch_taken),
      .hold         (hold),
      .mem_req      (mem_req),
      .mem_we       (mem_we),
      .iord         (iord),
      .ir_write     (ir_write),
      .pc_write     (pc_write),
      .pc_src       (pc_src),
      .reg_write    (reg_write),
      .reg_dest     (reg_dest),
      .mem_to_reg   (mem_to_reg),
      .alu_src      (alu_src),
      .alu_ipsel    (alu_ipsel),
      .alu_opsel    (alu_opsel),
      .illegal      (illegal),
      .state_o      (state_o)
   );

   typedef struct packed {
      logic [2:0] st;
      logic       req, we, io, irw, pcw;
      logic [1:0] pcs;
      logic       rw;
      logic [1:0] rd, m2r;
      logic       src, ips;
      logic [4:0] op;
      logic       ill;
   } exp_t;

   localparam logic [2:0] SF = 3'd0, SD = 3'd1, SE = 3'd2, SM = 3'd3, SW = 3'd4, ST = 3'd5;

   string nq[$];
   exp_t  eq[$];
   int    n_checks = 0;
   int    n_fail   = 0;
   exp_t  e_mon, a_mon;
   string nm_mon;

   function automatic exp_t E(input logic [2:0] st, input logic req, we, io, irw, pcw,
                              input logic [1:0] pcs, input logic rw, input logic [1:0] rd, m2r,
                              input logic src, ips, input logic [4:0] op, input logic ill);
      exp_t r;
      r = '{st:st, req:req, we:we, io:io, irw:irw, pcw:pcw, pcs:pcs, rw:rw,
            rd:rd, m2r:m2r, src:src, ips:ips, op:op, ill:ill};
      return r;
   endfunction

   always @(negedge clk) begin
      if (eq.size() > 0) begin
         e_mon  = eq.pop_front();
         nm_mon = nq.pop_front();
         a_mon  = '{st:state_o, req:mem_req, we:mem_we, io:iord, irw:ir_write, pcw:pc_write,
                    pcs:pc_src, rw:reg_write, rd:reg_dest, m2r:mem_to_reg, src:alu_src,
                    ips:alu_ipsel, op:alu_opsel, ill:illegal};
         n_checks++;
         if (a_mon !== e_mon) begin
            n_fail++;
            $display("FAIL %s: actual=%b required=%b (st|req we io irw pcw|pcs|rw|rd|m2r|src ips|op|ill)",
                     nm_mon, a_mon, e_mon);
         end
      end
   end

   task automatic cyc(input string nm, input logic rn, rdy, tk, hd, input exp_t e);
      rst_n        = rn;
      mem_ready    = rdy;
      branch_taken = tk;
      hold         = hd;
      nq.push_back(nm);
      eq.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic set_ir(input logic [5:0] op, input logic [4:0] fn);
      opcode = op;
      func   = fn;
   endtask

   exp_t RSTZ, F_GO, F_WAIT, DEC;

   initial begin
      RSTZ   = E(SF,0,0,0,0,0,2'd0,0,2'd0,2'd0,0,0,5'd0,0);
      F_GO   = E(SF,1,0,0,1,1,2'd0,0,2'd0,2'd0,0,0,5'd0,0);
      F_WAIT = E(SF,1,0,0,0,0,2'd0,0,2'd0,2'd0,0,0,5'd0,0);
      DEC    = E(SD,0,0,0,0,0,2'd0,0,2'd0,2'd0,0,0,5'd0,0);

      rst_n = 1'b0; mem_ready = 1'b0; branch_taken = 1'b0; hold = 1'b0;
      set_ir(6'd0, 5'd0);
      @(posedge clk);
      #1;

      cyc("reset0", 0,1,0,0, RSTZ);
      cyc("reset1", 0,1,0,0, RSTZ);

      // add
      set_ir(6'd0, 5'd0);
      cyc("add_fetch", 1,1,0,0, F_GO);
      cyc("add_dec",   1,1,0,0, DEC);
      cyc("add_exec",  1,1,0,0, E(SE,0,0,0,0,0,2'd0,0,2'd0,2'd0,0,0,5'b00001,0));
      cyc("add_wb",    1,1,0,0, E(SW,0,0,0,0,0,2'd0,1,2'd0,2'd2,0,0,5'b00001,0));

      // comp
      set_ir(6'd0, 5'd1);
      cyc("comp_fetch", 1,1,0,0, F_GO);
      cyc("comp_dec",   1,1,0,0, DEC);
      cyc("comp_exec",  1,1,0,0, E(SE,0,0,0,0,0,2'd0,0,2'd0,2'd0,0,1,5'b00010,0));
      cyc("comp_wb",    1,1,0,0, E(SW,0,0,0,0,0,2'd0,1,2'd0,2'd2,0,1,5'b00010,0));

      // shra immediate
      set_ir(6'd2, 5'd4);
      cyc("shra_fetch", 1,1,0,0, F_GO);
      cyc("shra_dec",   1,1,0,0, DEC);
      cyc("shra_exec",  1,1,0,0, E(SE,0,0,0,0,0,2'd0,0,2'd0,2'd0,1,0,5'b01001,0));
      cyc("shra_wb",    1,1,0,0, E(SW,0,0,0,0,0,2'd0,1,2'd0,2'd2,1,0,5'b01001,0));

      // xor
      set_ir(6'd1, 5'd1);
      cyc("xor_fetch", 1,1,0,0, F_GO);
      cyc("xor_dec",   1,1,0,0, DEC);
      cyc("xor_exec",  1,1,0,0, E(SE,0,0,0,0,0,2'd0,0,2'd0,2'd0,0,0,5'b00100,0));
      cyc("xor_wb",    1,1,0,0, E(SW,0,0,0,0,0,2'd0,1,2'd0,2'd2,0,0,5'b00100,0));

      // lw with two wait cycles in MEM: 7 cycles
      set_ir(6'd6, 5'd0);
      cyc("lw_fetch", 1,1,0,0, F_GO);
      cyc("lw_dec",   1,1,0,0, DEC);
      cyc("lw_exec",  1,1,0,0, E(SE,0,0,0,0,0,2'd0,0,2'd0,2'd0,1,0,5'b00110,0));
      cyc("lw_mem0",  1,0,0,0, E(SM,1,0,1,0,0,2'd0,0,2'd0,2'd0,1,0,5'b00110,0));
      cyc("lw_mem1",  1,0,0,0, E(SM,1,0,1,0,0,2'd0,0,2'd0,2'd0,1,0,5'b00110,0));
      cyc("lw_mem2",  1,1,0,0, E(SM,1,0,1,0,0,2'd0,0,2'd0,2'd0,1,0,5'b00110,0));
      cyc("lw_wb",    1,1,0,0, E(SW,0,0,0,0,0,2'd0,1,2'd1,2'd1,1,0,5'b00110,0));

      // sw with one wait in FETCH
      set_ir(6'd7, 5'd0);
      cyc("sw_fetch_wait", 1,0,0,0, F_WAIT);
      cyc("sw_fetch",      1,1,0,0, F_GO);
      cyc("sw_dec",        1,1,0,0, DEC);
      cyc("sw_exec",       1,1,0,0, E(SE,0,0,0,0,0,2'd0,0,2'd0,2'd0,1,0,5'b00110,0));
      cyc("sw_mem",        1,1,0,0, E(SM,1,1,1,0,0,2'd0,0,2'd0,2'd0,1,0,5'b00110,0));

      // conditional branch, not taken then taken
      set_ir(6'd8, 5'd0);
      cyc("b8n_fetch", 1,1,0,0, F_GO);
      cyc("b8n_dec",   1,1,0,0, DEC);
      cyc("b8n_exec",  1,1,0,0, E(SE,0,0,0,0,0,2'd1,0,2'd0,2'd0,0,0,5'd0,0));
      cyc("b8t_fetch", 1,1,1,0, F_GO);
      cyc("b8t_dec",   1,1,1,0, DEC);
      cyc("b8t_exec",  1,1,1,0, E(SE,0,0,0,0,1,2'd1,0,2'd0,2'd0,0,0,5'd0,0));

      // jump register
      set_ir(6'd11, 5'd0);
      cyc("br_fetch", 1,1,0,0, F_GO);
      cyc("br_dec",   1,1,0,0, DEC);
      cyc("br_exec",  1,1,0,0, E(SE,0,0,0,0,1,2'd2,0,2'd0,2'd0,0,0,5'd0,0));

      // branch and link
      set_ir(6'd13, 5'd0);
      cyc("bl_fetch", 1,1,0,0, F_GO);
      cyc("bl_dec",   1,1,0,0, DEC);
      cyc("bl_exec",  1,1,0,0, E(SE,0,0,0,0,1,2'd1,1,2'd2,2'd0,0,0,5'd0,0));

      // addi: hold in FETCH with ready, then hold 3 cycles in EXEC
      set_ir(6'd4, 5'd0);
      cyc("addi_fetch_hold", 1,1,0,1, F_WAIT);
      cyc("addi_fetch",      1,1,0,0, F_GO);
      cyc("addi_dec",        1,1,0,0, DEC);
      for (int i = 0; i < 3; i++)
         cyc("addi_exec_hold", 1,1,0,1, E(SE,0,0,0,0,0,2'd0,0,2'd0,2'd0,1,0,5'b00001,0));
      cyc("addi_exec", 1,1,0,0, E(SE,0,0,0,0,0,2'd0,0,2'd0,2'd0,1,0,5'b00001,0));
      cyc("addi_wb",   1,1,0,0, E(SW,0,0,0,0,0,2'd0,1,2'd0,2'd2,1,0,5'b00001,0));

      // undefined func 7 on opcode 0: trap until reset
      set_ir(6'd0, 5'd7);
      cyc("trapf_fetch", 1,1,0,0, F_GO);
      cyc("trapf_dec",   1,1,0,0, DEC);
      for (int i = 0; i < 3; i++)
         cyc("trapf_trap", 1,1,0,0, E(ST,0,0,0,0,0,2'd0,0,2'd0,2'd0,0,0,5'd0,1));
      cyc("trapf_reset", 0,1,0,0, RSTZ);

      // opcode 16 is the first undefined opcode
      set_ir(6'd16, 5'd0);
      cyc("trapo_fetch", 1,1,0,0, F_GO);
      cyc("trapo_dec",   1,1,0,0, DEC);
      cyc("trapo_trap",  1,1,0,0, E(ST,0,0,0,0,0,2'd0,0,2'd0,2'd0,0,0,5'd0,1));
      cyc("trapo_reset", 0,1,0,0, RSTZ);

      // store abandoned by reset in MEM
      set_ir(6'd7, 5'd0);
      cyc("swr_fetch", 1,1,0,0, F_GO);
      cyc("swr_dec",   1,1,0,0, DEC);
      cyc("swr_exec",  1,1,0,0, E(SE,0,0,0,0,0,2'd0,0,2'd0,2'd0,1,0,5'b00110,0));
      cyc("swr_mem_reset", 0,1,0,0, RSTZ);
      cyc("swr_after", 1,0,0,0, F_WAIT);

      @(negedge clk);
      #1;
      if (eq.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: actual=%0d pending required=0", eq.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
